// File: rtl/main_memory_pkg.sv
// Shared types and helpers for the block-granular main memory model.
// Word width, block size and address width normally come from config.sv;
// the guarded defaults below keep the block buildable on its own.
// Optional feature macro: MAIN_MEMORY_PERF_CNT_EN (read/write completion counters).
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif

package main_memory_pkg;

   localparam int WORD_W        = `DRAM_WORD_SIZE;
   localparam int BLK           = `DRAM_BLOCK_SIZE;
   localparam int ADDR_W        = `DRAM_ADDRESS_SIZE;
   localparam int MM_NUM_BLOCKS = 1024;

   // Ceiling log2, usable in constant expressions.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((int'(1) << i) < value) r = i + 1;
      end
      return r;
   endfunction

   localparam int IDX_W = log2(MM_NUM_BLOCKS);
   // Byte + word-offset bits below the block index.
   localparam int OFF_W = log2(BLK) + 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_BUSY    = 3'b010,
      ST_RESPOND = 3'b100
   } mm_state_t;

   typedef logic [WORD_W-1:0] mm_block_t [BLK];

endpackage

// File: rtl/main_memory_storage.sv
// Backing store: NUM_BLOCKS whole blocks, synchronous write, registered read.
// A read in the same cycle as a write to the same index returns the old block.
module main_memory_storage
   import main_memory_pkg::*;
#(
   parameter int NUM_BLOCKS = 2 ** IDX_W
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [log2(NUM_BLOCKS)-1:0]   index,
   input  mm_block_t                     wdata,
   output mm_block_t                     rdata
);

   logic [WORD_W-1:0] mem [NUM_BLOCKS][BLK];

   // Commit a whole block on we; always register the addressed block for reading.
   always_ff @(posedge clk) begin
      for (int w = 0; w < BLK; w++) begin
         if (we) mem[index][w] <= wdata[w];
         rdata[w] <= mem[index][w];
      end
   end

endmodule

// File: rtl/main_memory_controller.sv
// Main memory controller: accepts one whole-block request from the dcache,
// answers LATENCY cycles later with a one-cycle mem_ready pulse (plus the
// block for reads). FSM IDLE -> BUSY -> RESPOND, with RESPOND able to accept
// the next request directly (write-back followed by allocate).
// Optional feature macro: MAIN_MEMORY_PERF_CNT_EN adds rd_count / wr_count.
// Handshake: a request is taken on any edge where mem_valid = 1 and the FSM is
// in IDLE or RESPOND; mem_rw/mem_address/mem_data_out matter only on that edge.
module main_memory_controller
   import main_memory_pkg::*;
#(
   parameter int LATENCY    = 8,
   parameter int NUM_BLOCKS = MM_NUM_BLOCKS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  mem_address,
   input  mm_block_t          mem_data_out,
   input  logic               mem_rw,
   input  logic               mem_valid,
   output mm_block_t          mem_data_in,
   output logic               mem_ready
`ifdef MAIN_MEMORY_PERF_CNT_EN
   ,
   output logic [31:0]        rd_count,
   output logic [31:0]        wr_count
`endif
);

   localparam int IW = log2(NUM_BLOCKS);

   mm_state_t       state, state_nxt;
   logic [7:0]      cnt, cnt_nxt;
   logic            accept, go_respond;
   logic [IW-1:0]   addr_idx, req_idx, st_index;
   logic            req_rw, st_we;
   mm_block_t       req_data, st_wdata, st_rdata, hold_q;
   logic            addr_unused;

   assign addr_idx    = mem_address[OFF_W +: IW];
   assign addr_unused = ^{mem_address[ADDR_W-1:OFF_W+IW], mem_address[OFF_W-1:0]};

   // Next state, latency counter and response pulse.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      accept     = 1'b0;
      go_respond = 1'b0;
      mem_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_valid) accept = 1'b1;
         end
         ST_BUSY: begin
            if (cnt <= 8'd1) begin
               state_nxt  = ST_RESPOND;
               go_respond = 1'b1;
               cnt_nxt    = 8'd0;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         ST_RESPOND: begin
            mem_ready = 1'b1;
            state_nxt = ST_IDLE;
            if (mem_valid) accept = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (accept) begin
         if (LATENCY == 1) begin
            state_nxt  = ST_RESPOND;
            go_respond = 1'b1;
            cnt_nxt    = 8'd0;
         end else begin
            state_nxt = ST_BUSY;
            cnt_nxt   = 8'(LATENCY - 1);
         end
      end
   end

   // Storage port steering: a write commits on the edge that enters RESPOND,
   // so a read accepted during that RESPOND already sees the new block.
   always_comb begin
      st_index = accept ? addr_idx : req_idx;
      st_we    = reset && go_respond && (accept ? mem_rw : req_rw);
      for (int w = 0; w < BLK; w++) begin
         st_wdata[w] = accept ? mem_data_out[w] : req_data[w];
      end
   end

   // Read data is live from storage during a read RESPOND, else the held block.
   always_comb begin
      for (int w = 0; w < BLK; w++) begin
         mem_data_in[w] = (state == ST_RESPOND && !req_rw) ? st_rdata[w] : hold_q[w];
      end
   end

   // FSM state and latency counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Request latch, loaded only on the accept edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_idx <= addr_idx;
         req_rw  <= mem_rw;
         for (int w = 0; w < BLK; w++) req_data[w] <= mem_data_out[w];
      end
   end

   // Hold the last returned read block until the next read responds.
   always_ff @(posedge clk) begin
      for (int w = 0; w < BLK; w++) begin
         if (!reset) hold_q[w] <= '0;
         else if (state == ST_RESPOND && !req_rw) hold_q[w] <= st_rdata[w];
      end
   end

   main_memory_storage #(.NUM_BLOCKS(NUM_BLOCKS)) u_storage (
      .clk   (clk),
      .we    (st_we),
      .index (st_index),
      .wdata (st_wdata),
      .rdata (st_rdata)
   );

`ifdef MAIN_MEMORY_PERF_CNT_EN
   // Saturating completion counters, stepped on each mem_ready.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_count <= 32'd0;
         wr_count <= 32'd0;
      end else if (state == ST_RESPOND) begin
         if (req_rw) begin
            if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
         end else begin
            if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_main_memory_controller.sv
// Directed bench for main_memory_controller (LATENCY = 4, 4-word blocks, 1024 blocks).
module tb_main_memory_controller;
   import main_memory_pkg::*;

   localparam int LAT = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] mem_address = '0;
   mm_block_t         mem_data_out;
   logic              mem_rw = 1'b0;
   logic              mem_valid = 1'b0;
   mm_block_t         mem_data_in;
   logic              mem_ready;
`ifdef MAIN_MEMORY_PERF_CNT_EN
   logic [31:0]       rd_count, wr_count;
`endif

   int                n_cmp = 0;
   int                n_bad = 0;
   logic [WORD_W-1:0] exp_q[$];

   main_memory_controller #(.LATENCY(LAT), .NUM_BLOCKS(1024)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_address  (mem_address),
      .mem_data_out (mem_data_out),
      .mem_rw       (mem_rw),
      .mem_valid    (mem_valid),
      .mem_data_in  (mem_data_in),
      .mem_ready    (mem_ready)
`ifdef MAIN_MEMORY_PERF_CNT_EN
      ,
      .rd_count     (rd_count),
      .wr_count     (wr_count)
`endif
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_block(input logic [31:0] base);
      for (int w = 0; w < BLK; w++) exp_q.push_back(WORD_W'(base + 32'(w)));
   endtask

   task automatic check_block(input string tag);
      logic [WORD_W-1:0] e;
      for (int w = 0; w < BLK; w++) begin
         e = exp_q.pop_front();
         check($sformatf("%s_w%0d", tag, w), 32'(mem_data_in[w]), 32'(e));
      end
   endtask

   // drivers
   task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] base);
      @(posedge clk); #1;
      mem_rw      = rw;
      mem_address = ADDR_W'(addr);
      for (int w = 0; w < BLK; w++) mem_data_out[w] = WORD_W'(base + 32'(w));
      mem_valid   = 1'b1;
      @(posedge clk); #1;
      // scramble everything after the accept edge
      mem_valid   = 1'b0;
      mem_rw      = ~rw;
      mem_address = ~ADDR_W'(addr);
      for (int w = 0; w < BLK; w++) mem_data_out[w] = ~WORD_W'(base + 32'(w));
   endtask

   task automatic wait_ready(output int lat);
      bit seen;
      seen = 1'b0;
      lat  = -1;
      for (int i = 1; i <= 20; i++) begin
         if (!seen) begin
            @(negedge clk);
            if (mem_ready) begin
               seen = 1'b1;
               lat  = i;
            end
         end
      end
   endtask

   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (mem_ready) pulses++;
      end
   endtask

   task automatic write_blk(input string tag, input logic [31:0] addr, input logic [31:0] base);
      int lat;
      issue(1'b1, addr, base);
      wait_ready(lat);
      check({tag, "_lat"}, 32'(lat), 32'(LAT));
   endtask

   task automatic read_expect(input string tag, input logic [31:0] addr, input logic [31:0] base);
      int lat;
      push_block(base);
      issue(1'b0, addr, 32'h0);
      wait_ready(lat);
      check({tag, "_lat"}, 32'(lat), 32'(LAT));
      check_block(tag);
   endtask

   // stimulus
   initial begin
      int lat, pulses, first;
      for (int w = 0; w < BLK; w++) mem_data_out[w] = '0;

      // reset held low for three edges
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(mem_ready), 32'd0);
      for (int w = 0; w < BLK; w++) check($sformatf("rst_data_w%0d", w), 32'(mem_data_in[w]), 32'd0);
      check("rst_state", 32'(dut.state), 32'(ST_IDLE));
`ifdef MAIN_MEMORY_PERF_CNT_EN
      check("rst_rd_count", rd_count, 32'd0);
      check("rst_wr_count", wr_count, 32'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b1;

      // write then read (word-offset bits ignored), single pulse only
      write_blk("wr_a", 32'h40, 32'hA000_0000);
      count_pulses(6, pulses);
      check("wr_a_single", 32'(pulses), 32'd0);
      read_expect("rd_a", 32'h4C, 32'hA000_0000);

      // write-back -> allocate turnaround accepted in the write's RESPOND
      issue(1'b1, 32'h100, 32'hC000_0000);
      wait_ready(lat);
      check("ta_wr_lat", 32'(lat), 32'(LAT));
      mem_address = ADDR_W'(32'h100);
      mem_rw      = 1'b0;
      mem_valid   = 1'b1;
      push_block(32'hC000_0000);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      wait_ready(lat);
      check("ta_rd_lat", 32'(lat), 32'(LAT));
      check_block("ta_rd");

      // extra mem_valid while busy is ignored; read data keeps last read block
      issue(1'b1, 32'h200, 32'hD000_0000);
      pulses = 0;
      first  = -1;
      push_block(32'hC000_0000);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (mem_ready) begin
            pulses++;
            if (first < 0) begin
               first = i;
               check_block("busy_hold");
            end
         end
         if (i == 1) begin
            mem_address = ADDR_W'(32'h40);
            mem_rw      = 1'b0;
            mem_valid   = 1'b1;
         end
         if (i == 2) mem_valid = 1'b0;
      end
      check("busy_first", 32'(first), 32'(LAT));
      check("busy_pulses", 32'(pulses), 32'd1);
      read_expect("rd_d", 32'h200, 32'hD000_0000);

      // reset during a pending write drops it
      write_blk("wr_p", 32'h80, 32'h1111_0000);
      issue(1'b1, 32'h80, 32'hB000_0000);
      pulses = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (mem_ready) pulses++;
         if (i == 2) reset = 1'b0;
         if (i == 4) reset = 1'b1;
      end
      check("rstmid_pulses", 32'(pulses), 32'd0);
      check("rstmid_state", 32'(dut.state), 32'(ST_IDLE));
      for (int w = 0; w < BLK; w++) check($sformatf("rstmid_data_w%0d", w), 32'(mem_data_in[w]), 32'd0);
      read_expect("rd_p", 32'h80, 32'h1111_0000);

      // aliasing modulo NUM_BLOCKS and the top block index
      write_blk("wr_e", 32'h0, 32'hE000_0000);
      read_expect("rd_alias", 32'h4007, 32'hE000_0000);
      write_blk("wr_f", 32'h3FF0, 32'hF000_0000);
      read_expect("rd_top", 32'h3FF0, 32'hF000_0000);

`ifdef MAIN_MEMORY_PERF_CNT_EN
      // since the mid-op reset: 2 writes, 3 reads
      @(negedge clk);
      check("cnt_rd", rd_count, 32'd3);
      check("cnt_wr", wr_count, 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
